// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register: occupancy
// states, MEM/WB payload layout and per-stage payload widths.
package pipe_stage_reg_pkg;

  // Occupancy of a stage; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  // Write-back source select carried in the MEM/WB payload.
  typedef enum logic [1:0] {
    DEST_ALU = 2'd0,
    DEST_MEM = 2'd1,
    DEST_PC4 = 2'd2
  } data_dest_t;

  // MEM/WB payload field widths.
  localparam int PC_PLUS4_W    = 32;
  localparam int ALU_RESULT_W  = 32;
  localparam int MEM_RD_DATA_W = 32;
  localparam int DATA_DEST_W   = 2;
  localparam int REG_WR_ADDR_W = 5;
  localparam int REG_WR_SIG_W  = 1;

  // MEM/WB payload field offsets, LSB first.
  localparam int REG_WR_SIG_OFS  = 0;
  localparam int REG_WR_ADDR_OFS = REG_WR_SIG_OFS + REG_WR_SIG_W;
  localparam int DATA_DEST_OFS   = REG_WR_ADDR_OFS + REG_WR_ADDR_W;
  localparam int MEM_RD_DATA_OFS = DATA_DEST_OFS + DATA_DEST_W;
  localparam int ALU_RESULT_OFS  = MEM_RD_DATA_OFS + MEM_RD_DATA_W;
  localparam int PC_PLUS4_OFS    = ALU_RESULT_OFS + ALU_RESULT_W;

  // Per-stage payload widths used when instantiating stage registers.
  localparam int IFID_W  = 64;
  localparam int MEMWB_W = PC_PLUS4_OFS + PC_PLUS4_W;

  // Entry count corresponding to an occupancy state.
  function automatic logic [1:0] state_count(input occ_state_t s);
    return logic'(1'b0) ? 2'd0 : s;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage slot of a pipeline stage: a valid bit plus a payload register.
// Clear wins over load for the valid bit; the payload only changes on load.
module pipe_stage_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = 72,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Valid bit and payload register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
      if (load) begin
        data <= load_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, stall and
// flush. SKID=1 adds a second slot so in_ready_o depends only on state.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = 72,
  parameter int                SKID      = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] main_src;
  logic              accept;
  logic              emit;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic              main_next;
  logic              skid_next;
  logic [1:0]        count_next;
  occ_state_t        state;

  pipe_stage_slot #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_src),
    .valid     (main_v),
    .data      (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_stage_slot #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (in_data_i),
        .valid     (skid_v),
        .data      (skid_data)
      );
      assign in_ready_o = !skid_v && !flush_i;
    end else begin : g_single
      logic unused_skid_ctl;
      assign unused_skid_ctl = skid_load ^ skid_clear;
      assign skid_v          = 1'b0;
      assign skid_data       = RESET_VAL;
      assign in_ready_o      = (!main_v || out_ready_i) && !flush_i;
    end
  endgenerate

  assign out_valid_o = main_v;
  assign out_data_o  = main_data;
  assign count_o     = state_count(state);

  // Slot control: flush clears everything, a held skid entry refills main
  // on emit, otherwise incoming data goes to main if it is free or leaving.
  always_comb begin
    accept     = in_valid_i && in_ready_o;
    emit       = main_v && out_ready_i;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_src   = in_data_i;
    if (flush_i) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_v) begin
      if (emit) begin
        main_load  = 1'b1;
        main_src   = skid_data;
        skid_clear = 1'b1;
      end
    end else if (accept && (!main_v || emit)) begin
      main_load = 1'b1;
    end else if (accept) begin
      skid_load = 1'b1;
    end else if (emit) begin
      main_clear = 1'b1;
    end
    main_next  = main_clear ? 1'b0 : (main_load ? 1'b1 : main_v);
    skid_next  = skid_clear ? 1'b0 : (skid_load ? 1'b1 : skid_v);
    count_next = {1'b0, main_next} + {1'b0, skid_next};
  end

  // Occupancy state tracks the slot valids so count_o is a plain register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= occ_state_t'(count_next);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a single-entry and a skid instance share the
// same stimulus; each has its own expected-entry queue checked by a monitor.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int           W       = MEMWB_W;
  localparam logic [W-1:0] RST_VAL = 104'h5A5;

  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         in_ready  [2];
  logic         out_valid [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   count     [2];

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] sb0 [$];
  logic [W-1:0] sb1 [$];
  logic         hold_prev [2];
  logic [W-1:0] prev_data [2];

  pipe_stage_reg #(.DATA_W(W), .SKID(0), .RESET_VAL(RST_VAL)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .in_data_i(in_data),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_data_o(out_data[0]),
    .count_o(count[0])
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(1), .RESET_VAL(RST_VAL)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .in_data_i(in_data),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_data_o(out_data[1]),
    .count_o(count[1])
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void sb_push(input int d, input logic [W-1:0] v);
    if (d == 0) sb0.push_back(v);
    else        sb1.push_back(v);
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic [W-1:0] sb_pop(input int d);
    if (d == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  function automatic void sb_clear(input int d);
    if (d == 0) sb0.delete();
    else        sb1.delete();
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then record what will be
  // accepted at the next edge in each instance's expected queue.
  task automatic apply_stimulus(input logic rst_n, input logic v, input logic [W-1:0] d,
                                input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    reset_n   = rst_n;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    #3;
    for (int i = 0; i < 2; i++) begin
      if (reset_n && in_valid && in_ready[i]) sb_push(i, in_data);
    end
  endtask

  task automatic monitor_dut(input int d);
    int           sz;
    logic [W-1:0] exp;
    if (!reset_n) begin
      sb_clear(d);
      hold_prev[d] = 1'b0;
      return;
    end
    sz = sb_size(d);
    check_output($sformatf("count%0d", d), W'(count[d]), W'(sz));
    check_output($sformatf("out_valid%0d", d), W'(out_valid[d]), W'(sz != 0));
    if (hold_prev[d]) begin
      check_output($sformatf("stable_valid%0d", d), W'(out_valid[d]), W'(1));
      check_output($sformatf("stable_data%0d", d), out_data[d], prev_data[d]);
    end
    if (out_valid[d] && out_ready) begin
      if (sz == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL emit%0d: got %h expected no entry", d, out_data[d]);
      end else begin
        exp = sb_pop(d);
        check_output($sformatf("order%0d", d), out_data[d], exp);
      end
    end
    hold_prev[d] = out_valid[d] && !out_ready && !flush;
    prev_data[d] = out_data[d];
    if (flush) sb_clear(d);
  endtask

  // Monitor: mid-cycle, compare occupancy and emitted data with the queues.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      for (int d = 0; d < 2; d++) monitor_dut(d);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and random stimulus.
  initial begin
    logic [127:0] r;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    $display("[TB] reset");
    apply_stimulus(1'b0, 1'b1, W'(8'h77), 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, W'(8'h77), 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, W'(8'h11), 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("rst_valid%0d", d), W'(out_valid[d]), W'(0));
      check_output($sformatf("rst_count%0d", d), W'(count[d]), W'(0));
      check_output($sformatf("rst_data%0d", d), out_data[d], RST_VAL);
      check_output($sformatf("rst_ready%0d", d), W'(in_ready[d]), W'(1));
    end
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);

    $display("[TB] streaming");
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(1'b1, 1'b1, W'(i), 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) begin
        check_output($sformatf("stream_ready%0d", d), W'(in_ready[d]), W'(1));
        if (i > 1) check_output($sformatf("stream_data%0d", d), out_data[d], W'(i - 1));
      end
    end
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);

    $display("[TB] stall");
    apply_stimulus(1'b1, 1'b1, W'(8'hAA), 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, W'(8'hBB), 1'b0, 1'b0);
    check_output("stall_ready0", W'(in_ready[0]), W'(0));
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_output("stall_count1", W'(count[1]), W'(2));
    check_output("stall_ready1", W'(in_ready[1]), W'(0));
    check_output("stall_data1", out_data[1], W'(8'hAA));
    check_output("stall_count0", W'(count[0]), W'(1));
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check_output("full_ready1", W'(in_ready[1]), W'(0));
    check_output("full_data1", out_data[1], W'(8'hAA));
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check_output("refill_ready1", W'(in_ready[1]), W'(1));
    check_output("refill_data1", out_data[1], W'(8'hBB));
    check_output("refill_count1", W'(count[1]), W'(1));
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check_output("drain_count1", W'(count[1]), W'(0));

    $display("[TB] flush");
    apply_stimulus(1'b1, 1'b1, W'(8'hAA), 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, W'(8'hBB), 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, W'(8'hCC), 1'b1, 1'b1);
    check_output("flush_ready0", W'(in_ready[0]), W'(0));
    check_output("flush_ready1", W'(in_ready[1]), W'(0));
    check_output("flush_head1", out_data[1], W'(8'hAA));
    check_output("flush_count1", W'(count[1]), W'(2));
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check_output("post_flush_count1", W'(count[1]), W'(0));
    check_output("post_flush_valid1", W'(out_valid[1]), W'(0));
    check_output("post_flush_keep1", out_data[1], W'(8'hAA));
    check_output("post_flush_count0", W'(count[0]), W'(0));

    $display("[TB] flush with reset");
    apply_stimulus(1'b1, 1'b1, W'(8'hEE), 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, W'(8'hDD), 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("fr_count%0d", d), W'(count[d]), W'(0));
      check_output($sformatf("fr_data%0d", d), out_data[d], RST_VAL);
    end
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check_output("empty_flush_ready0", W'(in_ready[0]), W'(0));
    check_output("empty_flush_ready1", W'(in_ready[1]), W'(0));
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("ef_count%0d", d), W'(count[d]), W'(0));
      check_output($sformatf("ef_data%0d", d), out_data[d], RST_VAL);
      check_output($sformatf("ef_ready%0d", d), W'(in_ready[d]), W'(1));
    end

    $display("[TB] random");
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), r[W-1:0],
                     ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) check_output($sformatf("final_count%0d", d), W'(count[d]), W'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
